xgmii_tx_arb: RTL

Round-robin arbiter that shares one XGMII transmit port between NREQ frame sources: test-frame generators, reply engines and similar. It sits between the sources and `xgmii_txd`/`xgmii_txc`. It grants one source per frame, passes that source's 64-bit words through a registered mux, and enforces a minimum inter-frame gap. A watchdog cuts off runaway frames and terminates them with an error code.

---
 rtl/xgmii_pkg.sv | 43 ++++
 rtl/xgmii_tx_arb_rr_pick.sv | 39 +++
 rtl/xgmii_tx_arb.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/xgmii_pkg.sv
// rtl/xgmii_pkg.sv - shared XGMII constants, word type and arbiter state encoding
package xgmii_pkg;

  // XGMII control characters (lane value when the matching txc bit is set)
  localparam logic [7:0] XG_IDLE  = 8'h07;
  localparam logic [7:0] XG_START = 8'hfb;
  localparam logic [7:0] XG_TERM  = 8'hfd;
  localparam logic [7:0] XG_ERR   = 8'hfe;

  // All-idle word driven between frames and out of reset
  localparam logic [63:0] IDLE_TXD = {8{XG_IDLE}};
  localparam logic [7:0]  IDLE_TXC = 8'hff;

  // Watchdog cut-off word: error in lane 0, terminate in lane 1, idles above
  localparam logic [63:0] ABORT_TXD = {{6{XG_IDLE}}, XG_TERM, XG_ERR};
  localparam logic [7:0]  ABORT_TXC = 8'hff;

  // Arbiter states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  // One XGMII transfer: control flags plus 64-bit data
  typedef struct packed {
    logic [7:0]  txc;
    logic [63:0] txd;
  } xgmii_word_t;

  function automatic xgmii_word_t idle_word();
    xgmii_word_t w;
    w.txc = IDLE_TXC;
    w.txd = IDLE_TXD;
    return w;
  endfunction

  function automatic xgmii_word_t abort_word();
    xgmii_word_t w;
    w.txc = ABORT_TXC;
    w.txd = ABORT_TXD;
    return w;
  endfunction

endpackage

// File: rtl/xgmii_tx_arb_rr_pick.sv
// rtl/xgmii_tx_arb_rr_pick.sv - combinational round-robin pick of the first requester at or after ptr
module rr_pick
  import xgmii_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] pick,
  output logic [PW-1:0]   idx,
  output logic            any
);

  logic [PW:0]   sum;
  logic [PW-1:0] cand;

  // Walk ptr, ptr+1, ... wrapping at NREQ; the first set request wins
  always_comb begin
    pick = '0;
    idx  = '0;
    any  = 1'b0;
    sum  = '0;
    cand = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(NREQ)) begin
        sum = sum - (PW+1)'(NREQ);
      end
      cand = sum[PW-1:0];
      if (!any && req[cand]) begin
        any        = 1'b1;
        idx        = cand;
        pick[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/xgmii_tx_arb.sv
// rtl/xgmii_tx_arb.sv - round-robin frame arbiter sharing one XGMII transmit port
module xgmii_tx_arb
  import xgmii_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int IFG_WORDS = 2,
  parameter int MAX_WORDS = 200
) (
  input  logic               xgmii_clk,
  input  logic               sys_rst,
  input  logic [NREQ-1:0]    src_req,
  input  logic [NREQ*64-1:0] src_txd,
  input  logic [NREQ*8-1:0]  src_txc,
  input  logic [NREQ-1:0]    src_last,
  output logic [NREQ-1:0]    src_gnt,
  output logic [63:0]        xgmii_txd,
  output logic [7:0]         xgmii_txc,
  output logic               busy,
  output logic               abort,
  output logic [31:0]        frame_cnt,
  output logic [15:0]        abort_cnt
);

  localparam int PW = $clog2(NREQ);

  // Watchdog fires on the MAX_WORDS-th granted cycle; gap lasts IFG_WORDS cycles
  localparam logic [9:0] WCNT_LAST = 10'(MAX_WORDS - 1);
  localparam logic [3:0] GCNT_LAST = 4'(IFG_WORDS - 1);

  logic [1:0]      state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [PW-1:0]   sel_q, sel_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [9:0]      wcnt_q, wcnt_d;
  logic [3:0]      gcnt_q, gcnt_d;
  xgmii_word_t     out_q, out_d;
  logic            busy_q, busy_d;
  logic            abort_q, abort_d;
  logic [31:0]     frame_cnt_q, frame_cnt_d;
  logic [15:0]     abort_cnt_q, abort_cnt_d;

  logic [NREQ-1:0] pick_oh;
  logic [PW-1:0]   pick_idx;
  logic            pick_any;

  logic [63:0]     sel_txd;
  logic [7:0]      sel_txc;
  logic            sel_last;
  logic [PW-1:0]   next_ptr;

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req  (src_req),
    .ptr  (ptr_q),
    .pick (pick_oh),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // Route the granted source's lanes; other sources are never looked at
  always_comb begin
    sel_txd  = src_txd[{sel_q, 6'b0} +: 64];
    sel_txc  = src_txc[{sel_q, 3'b0} +: 8];
    sel_last = src_last[sel_q];
    next_ptr = (sel_q == PW'(NREQ - 1)) ? '0 : sel_q + 1'b1;
  end

  // Frame FSM: arbitrate in IDLE, pass words in GRANT, hold idles in GAP
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    sel_d       = sel_q;
    ptr_d       = ptr_q;
    wcnt_d      = wcnt_q;
    gcnt_d      = gcnt_q;
    out_d       = idle_word();
    abort_d     = 1'b0;
    frame_cnt_d = frame_cnt_q;
    abort_cnt_d = abort_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          gnt_d   = pick_oh;
          sel_d   = pick_idx;
          wcnt_d  = '0;
          state_d = ST_GRANT;
        end
      end

      ST_GRANT: begin
        out_d.txc = sel_txc;
        out_d.txd = sel_txd;
        wcnt_d    = wcnt_q + 10'd1;
        // A terminate on the watchdog's last cycle still counts as a clean frame
        if (sel_last) begin
          gnt_d       = '0;
          ptr_d       = next_ptr;
          frame_cnt_d = frame_cnt_q + 32'd1;
          gcnt_d      = '0;
          state_d     = ST_GAP;
        end else if (wcnt_q == WCNT_LAST) begin
          out_d       = abort_word();
          gnt_d       = '0;
          abort_d     = 1'b1;
          abort_cnt_d = abort_cnt_q + 16'd1;
          ptr_d       = next_ptr;
          gcnt_d      = '0;
          state_d     = ST_GAP;
        end
      end

      ST_GAP: begin
        if (gcnt_q == GCNT_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gcnt_d = gcnt_q + 4'd1;
        end
      end

      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset forces the idle word at once
  always_ff @(posedge xgmii_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      sel_q       <= '0;
      ptr_q       <= '0;
      wcnt_q      <= '0;
      gcnt_q      <= '0;
      out_q       <= idle_word();
      busy_q      <= 1'b0;
      abort_q     <= 1'b0;
      frame_cnt_q <= '0;
      abort_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      sel_q       <= sel_d;
      ptr_q       <= ptr_d;
      wcnt_q      <= wcnt_d;
      gcnt_q      <= gcnt_d;
      out_q       <= out_d;
      busy_q      <= busy_d;
      abort_q     <= abort_d;
      frame_cnt_q <= frame_cnt_d;
      abort_cnt_q <= abort_cnt_d;
    end
  end

  assign src_gnt   = gnt_q;
  assign xgmii_txd = out_q.txd;
  assign xgmii_txc = out_q.txc;
  assign busy      = busy_q;
  assign abort     = abort_q;
  assign frame_cnt = frame_cnt_q;
  assign abort_cnt = abort_cnt_q;

endmodule
